// File: rtl/temp_control_pkg.sv
// Shared constants for the temperature controller: the digit-entry "done" code,
// the conversion FSM encoding and small BCD arithmetic helpers.
package temp_control_pkg;

    localparam logic [1:0] INPUT_STATE_DONE = 2'd3;
    localparam logic [3:0] BCD_MAX          = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAPT = 3'd1,
        ST_HUNS = 3'd2,
        ST_TENS = 3'd3,
        ST_ONES = 3'd4,
        ST_CMP  = 3'd5
    } state_e;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        logic [3:0] res;
        if (digit > BCD_MAX) begin
            res = BCD_MAX;
        end else begin
            res = digit;
        end
        return res;
    endfunction

    // Shift-and-add keeps the x10 step free of a hardware multiplier.
    function automatic logic [9:0] times_ten(input logic [9:0] value);
        return (value << 3) + (value << 1);
    endfunction

    function automatic logic [9:0] mac_digit(input logic [9:0] acc, input logic [3:0] digit);
        return times_ten(acc) + {6'd0, digit};
    endfunction

endpackage

// File: rtl/temp_control_sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous bit into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next-state values for the two synchronizer stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/temp_control.sv
// BCD-to-binary temperature converter with hysteretic heat/cool demand outputs.
// Conversion is triggered by a synchronized rising edge of the "done" state code.
module temp_control
    import temp_control_pkg::*;
#(
    parameter int unsigned SETPOINT = 72,
    parameter int unsigned HYST     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] input_state,
    input  logic [3:0] digit_ones,
    input  logic [3:0] digit_tens,
    input  logic [3:0] digit_huns,
    output logic [9:0] temp_bin,
    output logic       valid,
    output logic       busy,
    output logic       heat,
    output logic       cool
);

    // 11-bit thresholds so SETPOINT+HYST up to 1998 compares without wrapping.
    localparam logic [10:0] HEAT_ON_TH  = 11'(SETPOINT - HYST);
    localparam logic [10:0] COOL_ON_TH  = 11'(SETPOINT + HYST);
    localparam logic [10:0] SETPOINT_TH = 11'(SETPOINT);

    logic        done_raw_s;
    logic        done_sync_s;
    logic        start_s;
    logic [3:0]  digit_sel_s;
    logic [9:0]  acc_mac_s;
    logic [10:0] acc_ext_s;

    state_e      state_d,     state_q;
    logic        done_prev_d, done_prev_q;
    logic [9:0]  acc_d,       acc_q;
    logic [3:0]  huns_d,      huns_q;
    logic [3:0]  tens_d,      tens_q;
    logic [3:0]  ones_d,      ones_q;
    logic [9:0]  temp_bin_d,  temp_bin_q;
    logic        valid_d,     valid_q;
    logic        busy_d,      busy_q;
    logic        heat_d,      heat_q;
    logic        cool_d,      cool_q;

    assign done_raw_s = (input_state == INPUT_STATE_DONE);

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (done_raw_s),
        .q   (done_sync_s)
    );

    assign start_s = done_sync_s & ~done_prev_q;

    // Select the captured digit folded in by the current accumulate step
    always_comb begin
        digit_sel_s = 4'd0;
        case (state_q)
            ST_HUNS: digit_sel_s = huns_q;
            ST_TENS: digit_sel_s = tens_q;
            ST_ONES: digit_sel_s = ones_q;
            default: digit_sel_s = 4'd0;
        endcase
        acc_mac_s = mac_digit(acc_q, digit_sel_s);
        acc_ext_s = {1'b0, acc_mac_s};
    end

    // FSM and datapath next-state logic; results are registered on the ONES->CMP
    // edge so temp_bin/heat/cool/valid are all visible during the CMP cycle.
    always_comb begin
        state_d     = state_q;
        done_prev_d = done_sync_s;
        acc_d       = acc_q;
        huns_d      = huns_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        temp_bin_d  = temp_bin_q;
        valid_d     = 1'b0;
        heat_d      = heat_q;
        cool_d      = cool_q;

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_CAPT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPT: begin
                huns_d  = clamp_bcd(digit_huns);
                tens_d  = clamp_bcd(digit_tens);
                ones_d  = clamp_bcd(digit_ones);
                acc_d   = 10'd0;
                state_d = ST_HUNS;
            end
            ST_HUNS: begin
                acc_d   = acc_mac_s;
                state_d = ST_TENS;
            end
            ST_TENS: begin
                acc_d   = acc_mac_s;
                state_d = ST_ONES;
            end
            ST_ONES: begin
                acc_d      = acc_mac_s;
                temp_bin_d = acc_mac_s;
                valid_d    = 1'b1;
                state_d    = ST_CMP;
                if (acc_ext_s < HEAT_ON_TH) begin
                    heat_d = 1'b1;
                end else if (acc_ext_s >= SETPOINT_TH) begin
                    heat_d = 1'b0;
                end else begin
                    heat_d = heat_q;
                end
                if (acc_ext_s > COOL_ON_TH) begin
                    cool_d = 1'b1;
                end else if (acc_ext_s <= SETPOINT_TH) begin
                    cool_d = 1'b0;
                end else begin
                    cool_d = cool_q;
                end
            end
            ST_CMP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_prev_q <= 1'b0;
            acc_q       <= 10'd0;
            huns_q      <= 4'd0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            temp_bin_q  <= 10'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            heat_q      <= 1'b0;
            cool_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_prev_q <= done_prev_d;
            acc_q       <= acc_d;
            huns_q      <= huns_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            temp_bin_q  <= temp_bin_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            heat_q      <= heat_d;
            cool_q      <= cool_d;
        end
    end

    assign temp_bin = temp_bin_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign heat     = heat_q;
    assign cool     = cool_q;

endmodule

// File: tb/tb_temp_control.sv
// Self-checking bench for temp_control: directed scenarios plus random conversions
// compared against a decimal/hysteresis reference model.
module tb_temp_control;
    import temp_control_pkg::*;

    localparam int SP = 72;
    localparam int HY = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] input_state;
    logic [3:0] digit_ones;
    logic [3:0] digit_tens;
    logic [3:0] digit_huns;
    logic [9:0] temp_bin;
    logic       valid;
    logic       busy;
    logic       heat;
    logic       cool;

    int total = 0;
    int bad   = 0;
    int m_heat = 0;
    int m_cool = 0;

    always #5 clk = ~clk;

    temp_control #(.SETPOINT(SP), .HYST(HY)) dut (
        .clk         (clk),
        .rst         (rst),
        .input_state (input_state),
        .digit_ones  (digit_ones),
        .digit_tens  (digit_tens),
        .digit_huns  (digit_huns),
        .temp_bin    (temp_bin),
        .valid       (valid),
        .busy        (busy),
        .heat        (heat),
        .cool        (cool)
    );

    function automatic int digit_val(input logic [3:0] d);
        return (int'(d) > 9) ? 9 : int'(d);
    endfunction

    function automatic logic [1:0] idle_code();
        logic [1:0] c;
        c = 2'($urandom_range(0, 3));
        while (c == INPUT_STATE_DONE) c = 2'($urandom_range(0, 3));
        return c;
    endfunction

    task automatic model_apply(input int t);
        if (t < SP - HY) m_heat = 1;
        else if (t >= SP) m_heat = 0;
        if (t > SP + HY) m_cool = 1;
        else if (t <= SP) m_cool = 0;
    endtask

    // Entered at a negedge; k counts rising edges after the input goes to DONE.
    // Start is seen after edge 2 (cycle N), so busy covers edges 3..7 and valid edge 7.
    task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                            input bit toggle, input string tag);
        int exp_t;
        int pulses;
        bit exp_busy;
        bit exp_valid;
        pulses = 0;
        exp_t = digit_val(h) * 100 + digit_val(t) * 10 + digit_val(o);
        digit_huns  = h;
        digit_tens  = t;
        digit_ones  = o;
        input_state = INPUT_STATE_DONE;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_busy  = (k >= 3) && (k <= 7);
            exp_valid = (k == 7);
            if (valid) pulses++;
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy k=%0d got=%b want=%b", tag, k, busy, exp_busy);
            end
            total++;
            if (valid !== exp_valid) begin
                bad++;
                $display("FAIL %s valid k=%0d got=%b want=%b", tag, k, valid, exp_valid);
            end
            if (k == 7) begin
                model_apply(exp_t);
                total++;
                if (temp_bin !== 10'(exp_t)) begin
                    bad++;
                    $display("FAIL %s temp_bin got=%0d want=%0d", tag, temp_bin, exp_t);
                end
                total++;
                if (heat !== m_heat[0]) begin
                    bad++;
                    $display("FAIL %s heat got=%b want=%0d (t=%0d)", tag, heat, m_heat, exp_t);
                end
                total++;
                if (cool !== m_cool[0]) begin
                    bad++;
                    $display("FAIL %s cool got=%b want=%0d (t=%0d)", tag, cool, m_cool, exp_t);
                end
                total++;
                if (heat && cool) begin
                    bad++;
                    $display("FAIL %s exclusive heat=%b cool=%b want not both", tag, heat, cool);
                end
            end
            if (k == 4) begin
                digit_huns = 4'($urandom);
                digit_tens = 4'($urandom);
                digit_ones = 4'($urandom);
            end
            if (toggle && k == 3) input_state = idle_code();
            if (toggle && k == 4) input_state = INPUT_STATE_DONE;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL %s pulses got=%0d want=1", tag, pulses);
        end
        input_state = idle_code();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({temp_bin, valid, busy, heat, cool} !== 14'd0) begin
            bad++;
            $display("FAIL %s outputs got temp=%0d v=%b b=%b h=%b c=%b want all 0",
                     tag, temp_bin, valid, busy, heat, cool);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        input_state = 2'd0;
        digit_huns = 4'd0;
        digit_tens = 4'd0;
        digit_ones = 4'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset_idle");
        m_heat = 0;
        m_cool = 0;
    endtask

    task automatic test_basic();
        run_conv(4'd0, 4'd7, 4'd2, 1'b0, "basic_072");
    endtask

    task automatic test_heat_seq();
        run_conv(4'd0, 4'd6, 4'd9, 1'b0, "heat_069");
        run_conv(4'd0, 4'd7, 4'd1, 1'b0, "heat_071");
        run_conv(4'd0, 4'd7, 4'd2, 1'b0, "heat_072");
    endtask

    task automatic test_cool_seq();
        run_conv(4'd0, 4'd7, 4'd5, 1'b0, "cool_075");
        run_conv(4'd0, 4'd7, 4'd3, 1'b0, "cool_073");
        run_conv(4'd0, 4'd7, 4'd2, 1'b0, "cool_072");
    endtask

    task automatic test_clamp();
        run_conv(4'd9, 4'd9, 4'd9, 1'b0, "clamp_999");
        run_conv(4'hC, 4'hF, 4'hA, 1'b0, "clamp_CFA");
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        digit_huns = 4'd1;
        digit_tens = 4'd2;
        digit_ones = 4'd3;
        input_state = INPUT_STATE_DONE;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        rst = 1'b1;
        #1;
        check_all_zero("rstmid_async");
        @(negedge clk);
        if (valid) pulses++;
        check_all_zero("rstmid_hold");
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rstmid_pulse got=%0d want=0", pulses);
        end
        m_heat = 0;
        m_cool = 0;
        rst = 1'b0;
        run_conv(4'd0, 4'd6, 4'd0, 1'b0, "rstmid_resume");
    endtask

    task automatic test_back_to_back();
        run_conv(4'd0, 4'd8, 4'd8, 1'b1, "b2b_toggle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_conv(4'($urandom), 4'($urandom), 4'($urandom),
                     1'($urandom_range(0, 1)), "random");
        end
        for (int i = 0; i < 15; i++) begin
            run_conv(4'd0, 4'($urandom_range(6, 7)), 4'($urandom_range(0, 9)),
                     1'b0, "random_band");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_heat_seq();
        test_cool_seq();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
